// File: rtl/ecu_timing_pkg.sv
// rtl/ecu_timing_pkg.sv - shared ECU timing types and helpers
package ecu_timing_pkg;

  localparam int c_NUM_PHASES = 4;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACQUIRE = 2'd1,
    S_LOCKED  = 2'd2
  } t_phaseMonState;

  // True when two or more bits are set.
  function automatic logic f_multi_hot(input logic [c_NUM_PHASES-1:0] i_v);
    return (i_v & (i_v - c_NUM_PHASES'(1))) != '0;
  endfunction

endpackage

// File: rtl/edge_sync_detect.sv
// rtl/edge_sync_detect.sv - per-bit 2-flop synchroniser with registered rising-edge pulse
module edge_sync_detect #(
  parameter int c_WIDTH = 1
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [c_WIDTH-1:0] i_async,
  output logic [c_WIDTH-1:0] o_rise
);

  logic [c_WIDTH-1:0] r_meta;
  logic [c_WIDTH-1:0] r_sync;
  logic [c_WIDTH-1:0] r_prev;
  logic [c_WIDTH-1:0] r_rise;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_meta <= '0;
      r_sync <= '0;
      r_prev <= '0;
      r_rise <= '0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
      r_rise <= r_sync & ~r_prev;
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/phase_period_monitor.sv
// rtl/phase_period_monitor.sv - period and phase-offset monitor for four phased period signals
module phase_period_monitor
  import ecu_timing_pkg::*;
#(
  parameter int                     c_COUNT_WIDTH  = 16,
  parameter int                     c_LOCK_PERIODS = 4,
  parameter logic [c_COUNT_WIDTH-1:0] c_TIMEOUT    = 16'hFFFF
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic [3:0]               i_periodPhased,
  output logic [c_COUNT_WIDTH-1:0] o_periodCount,
  output logic [c_COUNT_WIDTH-1:0] o_phaseOffset1,
  output logic [c_COUNT_WIDTH-1:0] o_phaseOffset2,
  output logic [c_COUNT_WIDTH-1:0] o_phaseOffset3,
  output logic                     o_valid,
  output logic                     o_locked,
  output logic                     o_seqError,
  output logic                     o_timeout
);

  localparam logic [3:0]               c_LOCK_CNT = 4'(c_LOCK_PERIODS);
  localparam logic [c_COUNT_WIDTH-1:0] c_ONE      = c_COUNT_WIDTH'(1);

  logic [c_NUM_PHASES-1:0] w_rise;
  logic                    w_multi;
  logic [1:0]              w_rise_idx;

  t_phaseMonState          r_state, w_state_nxt;
  logic [1:0]              r_expected, w_expected_nxt;
  logic [3:0]              r_goodCount, w_good_nxt, w_good_inc;
  logic [c_COUNT_WIDTH-1:0] r_count, w_count_nxt;
  logic [c_COUNT_WIDTH-1:0] r_shadow1, r_shadow2, r_shadow3;
  logic [c_COUNT_WIDTH-1:0] r_periodCount, r_offset1, r_offset2, r_offset3;
  logic                    r_valid, r_locked, r_seqError, r_timeout;
  logic                    w_valid_nxt, w_locked_nxt, w_seq_nxt, w_timeout_nxt;
  logic                    w_capture, w_publish;

  edge_sync_detect #(
    .c_WIDTH(c_NUM_PHASES)
  ) u_edge_sync_detect (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_async (i_periodPhased),
    .o_rise  (w_rise)
  );

  assign w_multi    = f_multi_hot(w_rise);
  assign w_rise_idx = w_rise[3] ? 2'd3 : (w_rise[2] ? 2'd2 : 2'd1);
  assign w_good_inc = (r_goodCount == 4'hF) ? r_goodCount : r_goodCount + 4'd1;

  // r_count holds cycles elapsed since the ch0 rise cycle, so it loads 1 the cycle after.
  always_comb begin
    w_state_nxt    = r_state;
    w_expected_nxt = r_expected;
    w_good_nxt     = r_goodCount;
    w_count_nxt    = r_count;
    w_valid_nxt    = 1'b0;
    w_seq_nxt      = 1'b0;
    w_locked_nxt   = r_locked;
    w_timeout_nxt  = r_timeout;
    w_capture      = 1'b0;
    w_publish      = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_count_nxt = '0;
        if (w_rise[0] && !w_multi) begin
          w_state_nxt    = S_ACQUIRE;
          w_expected_nxt = 2'd1;
          w_good_nxt     = 4'd0;
          w_timeout_nxt  = 1'b0;
          w_count_nxt    = c_ONE;
        end
      end
      default: begin
        w_count_nxt = r_count + c_ONE;
        if (w_multi) begin
          w_seq_nxt    = 1'b1;
          w_locked_nxt = 1'b0;
          w_good_nxt   = 4'd0;
          w_state_nxt  = S_IDLE;
          w_count_nxt  = '0;
        end else if (w_rise[0]) begin
          w_count_nxt    = c_ONE;
          w_expected_nxt = 2'd1;
          if (r_expected == 2'd0) begin
            w_publish   = 1'b1;
            w_valid_nxt = 1'b1;
            w_good_nxt  = w_good_inc;
            if (w_good_inc >= c_LOCK_CNT) begin
              w_state_nxt  = S_LOCKED;
              w_locked_nxt = 1'b1;
            end
          end else begin
            w_seq_nxt    = 1'b1;
            w_good_nxt   = 4'd0;
            w_locked_nxt = 1'b0;
            w_state_nxt  = S_ACQUIRE;
          end
        end else if (w_rise[3:1] != 3'b000) begin
          if (w_rise_idx == r_expected) begin
            w_capture      = 1'b1;
            w_expected_nxt = w_rise_idx + 2'd1;
          end else begin
            w_seq_nxt    = 1'b1;
            w_locked_nxt = 1'b0;
            w_good_nxt   = 4'd0;
            w_state_nxt  = S_IDLE;
            w_count_nxt  = '0;
          end
        end else if (r_count == c_TIMEOUT) begin
          w_timeout_nxt = 1'b1;
          w_locked_nxt  = 1'b0;
          w_state_nxt   = S_IDLE;
          w_count_nxt   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_expected    <= 2'd0;
      r_goodCount   <= 4'd0;
      r_count       <= '0;
      r_shadow1     <= '0;
      r_shadow2     <= '0;
      r_shadow3     <= '0;
      r_periodCount <= '0;
      r_offset1     <= '0;
      r_offset2     <= '0;
      r_offset3     <= '0;
      r_valid       <= 1'b0;
      r_locked      <= 1'b0;
      r_seqError    <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_expected  <= w_expected_nxt;
      r_goodCount <= w_good_nxt;
      r_count     <= w_count_nxt;
      r_valid     <= w_valid_nxt;
      r_locked    <= w_locked_nxt;
      r_seqError  <= w_seq_nxt;
      r_timeout   <= w_timeout_nxt;
      if (w_capture) begin
        case (w_rise_idx)
          2'd1:    r_shadow1 <= r_count;
          2'd2:    r_shadow2 <= r_count;
          default: r_shadow3 <= r_count;
        endcase
      end
      if (w_publish) begin
        r_periodCount <= r_count;
        r_offset1     <= r_shadow1;
        r_offset2     <= r_shadow2;
        r_offset3     <= r_shadow3;
      end
    end
  end

  assign o_periodCount  = r_periodCount;
  assign o_phaseOffset1 = r_offset1;
  assign o_phaseOffset2 = r_offset2;
  assign o_phaseOffset3 = r_offset3;
  assign o_valid        = r_valid;
  assign o_locked       = r_locked;
  assign o_seqError     = r_seqError;
  assign o_timeout      = r_timeout;

endmodule

// File: tb/tb_phase_period_monitor.sv
// tb/tb_phase_period_monitor.sv - directed self-checking bench for phase_period_monitor
module tb_phase_period_monitor;

  localparam int P = 400;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b1;
  logic [3:0]  i_periodPhased = 4'b0000;
  logic [15:0] o_periodCount, o_phaseOffset1, o_phaseOffset2, o_phaseOffset3;
  logic        o_valid, o_locked, o_seqError, o_timeout;

  always #5 i_clock = ~i_clock;

  phase_period_monitor #(
    .c_COUNT_WIDTH (16),
    .c_LOCK_PERIODS(4),
    .c_TIMEOUT     (16'd1000)
  ) dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_periodPhased(i_periodPhased),
    .o_periodCount (o_periodCount),
    .o_phaseOffset1(o_phaseOffset1),
    .o_phaseOffset2(o_phaseOffset2),
    .o_phaseOffset3(o_phaseOffset3),
    .o_valid       (o_valid),
    .o_locked      (o_locked),
    .o_seqError    (o_seqError),
    .o_timeout     (o_timeout)
  );

  int tests = 0;
  int fails = 0;
  int n_valid = 0;
  int n_seq = 0;
  int cyc = 0;
  int last_valid_cyc = 0;
  logic [15:0] v_period, v_off1, v_off2, v_off3;
  logic v_locked;

  int ph = 0;
  int off [4] = '{0, 100, 200, 300};
  logic [3:0] en = 4'b0000;
  logic [3:0] armed = 4'b0000;

  // A channel only drives after its first in-phase rising point, so enabling never creates a spurious rise.
  task automatic tick();
    logic [3:0] lvl;
    int d;
    @(posedge i_clock);
    #1;
    cyc++;
    if (o_valid) begin
      n_valid++;
      last_valid_cyc = cyc;
      v_period = o_periodCount;
      v_off1 = o_phaseOffset1;
      v_off2 = o_phaseOffset2;
      v_off3 = o_phaseOffset3;
      v_locked = o_locked;
    end
    if (o_seqError) n_seq++;
    for (int k = 0; k < 4; k++) begin
      d = (ph - off[k] + P) % P;
      if (!en[k]) armed[k] = 1'b0;
      else if (d == 0) armed[k] = 1'b1;
      lvl[k] = armed[k] && en[k] && (d < P / 2);
    end
    i_periodPhased = lvl;
    ph = (ph + 1) % P;
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_period();
    ph = 0;
    run_ticks(P);
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    run_ticks(3);
    tests++;
    if ({o_valid, o_locked, o_seqError, o_timeout} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_flags: got %b want 0000", {o_valid, o_locked, o_seqError, o_timeout});
    end
    tests++;
    if ({o_periodCount, o_phaseOffset1, o_phaseOffset2, o_phaseOffset3} !== 64'd0) begin
      fails++;
      $display("FAIL reset_values: got %0d/%0d/%0d/%0d want 0/0/0/0",
               o_periodCount, o_phaseOffset1, o_phaseOffset2, o_phaseOffset3);
    end
    i_reset = 1'b0;
    run_ticks(20);
    tests++;
    if (n_valid != 0 || n_seq != 0 || o_timeout !== 1'b0) begin
      fails++;
      $display("FAIL idle_quiet: got valid=%0d seq=%0d timeout=%b want 0 0 0", n_valid, n_seq, o_timeout);
    end
  endtask

  task automatic test_clean_lock();
    int prev_cyc;
    en = 4'b1111;
    for (int i = 1; i <= 5; i++) begin
      prev_cyc = last_valid_cyc;
      run_period();
      tests++;
      if (n_valid != i - 1) begin
        fails++;
        $display("FAIL lock_valid_count p%0d: got %0d want %0d", i, n_valid, i - 1);
      end
      if (i >= 2) begin
        tests++;
        if (v_period !== 16'd400 || v_off1 !== 16'd100 || v_off2 !== 16'd200 || v_off3 !== 16'd300) begin
          fails++;
          $display("FAIL lock_values p%0d: got %0d/%0d/%0d/%0d want 400/100/200/300",
                   i, v_period, v_off1, v_off2, v_off3);
        end
        tests++;
        if (v_locked !== (i == 5)) begin
          fails++;
          $display("FAIL lock_flag p%0d: got %b want %b", i, v_locked, (i == 5));
        end
      end
      if (i >= 3) begin
        tests++;
        if (last_valid_cyc - prev_cyc != P) begin
          fails++;
          $display("FAIL valid_spacing p%0d: got %0d want %0d", i, last_valid_cyc - prev_cyc, P);
        end
      end
    end
  endtask

  task automatic test_swapped();
    int bv, bs;
    bv = n_valid;
    bs = n_seq;
    off[1] = 200;
    off[2] = 100;
    run_period();
    off[1] = 100;
    off[2] = 200;
    tests++;
    if (n_seq != bs + 1 || n_valid != bv + 1) begin
      fails++;
      $display("FAIL swap_pulses: got seq=%0d valid=%0d want %0d %0d", n_seq - bs, n_valid - bv, 1, 1);
    end
    tests++;
    if (o_locked !== 1'b0) begin
      fails++;
      $display("FAIL swap_unlock: got %b want 0", o_locked);
    end
    tests++;
    if (o_periodCount !== 16'd400 || o_phaseOffset1 !== 16'd100 || o_phaseOffset2 !== 16'd200 || o_phaseOffset3 !== 16'd300) begin
      fails++;
      $display("FAIL swap_hold: got %0d/%0d/%0d/%0d want 400/100/200/300",
               o_periodCount, o_phaseOffset1, o_phaseOffset2, o_phaseOffset3);
    end
    for (int i = 1; i <= 5; i++) begin
      run_period();
      tests++;
      if (o_locked !== (i == 5)) begin
        fails++;
        $display("FAIL relock p%0d: got %b want %b", i, o_locked, (i == 5));
      end
    end
    tests++;
    if (n_valid != bv + 5 || n_seq != bs + 1) begin
      fails++;
      $display("FAIL relock_counts: got valid=%0d seq=%0d want %0d %0d", n_valid - bv, n_seq - bs, 5, 1);
    end
  endtask

  task automatic test_missing_channel();
    int bv, bs;
    bv = n_valid;
    bs = n_seq;
    en[3] = 1'b0;
    run_period();
    en[3] = 1'b1;
    tests++;
    if (n_valid != bv + 1 || n_seq != bs) begin
      fails++;
      $display("FAIL missing_first: got valid=%0d seq=%0d want 1 0", n_valid - bv, n_seq - bs);
    end
    run_period();
    tests++;
    if (n_seq != bs + 1 || n_valid != bv + 1 || o_locked !== 1'b0) begin
      fails++;
      $display("FAIL missing_error: got seq=%0d valid=%0d locked=%b want 1 1 0", n_seq - bs, n_valid - bv, o_locked);
    end
    run_period();
    tests++;
    if (n_valid != bv + 2 || v_period !== 16'd400 || v_off3 !== 16'd300) begin
      fails++;
      $display("FAIL missing_resume: got valid=%0d period=%0d off3=%0d want 2 400 300", n_valid - bv, v_period, v_off3);
    end
  endtask

  task automatic test_timeout();
    int bv;
    bit seen;
    run_period();
    run_period();
    run_period();
    tests++;
    if (o_locked !== 1'b1) begin
      fails++;
      $display("FAIL timeout_prelock: got %b want 1", o_locked);
    end
    en = 4'b0000;
    seen = 0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      tick();
      if (o_timeout) seen = 1;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL timeout_seen: got none want pulse within 2000 cycles");
    end else if (cyc - last_valid_cyc != 1000 || o_locked !== 1'b0) begin
      fails++;
      $display("FAIL timeout_timing: got delay=%0d locked=%b want 1000 0", cyc - last_valid_cyc, o_locked);
    end
    run_ticks(50);
    tests++;
    if (o_timeout !== 1'b1) begin
      fails++;
      $display("FAIL timeout_sticky: got %b want 1", o_timeout);
    end
    bv = n_valid;
    en = 4'b1111;
    run_period();
    tests++;
    if (o_timeout !== 1'b0 || n_valid != bv) begin
      fails++;
      $display("FAIL timeout_clear: got timeout=%b valid=%0d want 0 0", o_timeout, n_valid - bv);
    end
  endtask

  task automatic test_back_to_back_edges();
    int bv, bs;
    bv = n_valid;
    bs = n_seq;
    off[2] = 100;
    run_period();
    off[2] = 200;
    tests++;
    if (n_seq != bs + 1 || n_valid != bv + 1) begin
      fails++;
      $display("FAIL simul_pulses: got seq=%0d valid=%0d want 1 1", n_seq - bs, n_valid - bv);
    end
    run_period();
    tests++;
    if (n_valid != bv + 1 || n_seq != bs + 1) begin
      fails++;
      $display("FAIL simul_idle: got valid=%0d seq=%0d want 1 1", n_valid - bv, n_seq - bs);
    end
    run_period();
    tests++;
    if (n_valid != bv + 2 || v_off1 !== 16'd100 || v_off2 !== 16'd200) begin
      fails++;
      $display("FAIL simul_recover: got valid=%0d off1=%0d off2=%0d want 2 100 200", n_valid - bv, v_off1, v_off2);
    end
  endtask

  task automatic test_reset_mid_period();
    int bv;
    run_period();
    run_period();
    run_period();
    tests++;
    if (o_locked !== 1'b1) begin
      fails++;
      $display("FAIL midreset_prelock: got %b want 1", o_locked);
    end
    bv = n_valid;
    ph = 0;
    run_ticks(150);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    tests++;
    if ({o_valid, o_locked, o_seqError, o_timeout} !== 4'b0000 ||
        {o_periodCount, o_phaseOffset1, o_phaseOffset2, o_phaseOffset3} !== 64'd0) begin
      fails++;
      $display("FAIL midreset_clear: got flags=%b period=%0d off1=%0d want 0000 0 0",
               {o_valid, o_locked, o_seqError, o_timeout}, o_periodCount, o_phaseOffset1);
    end
    run_ticks(P - 151);
    run_period();
    tests++;
    if (n_valid != bv + 1) begin
      fails++;
      $display("FAIL midreset_novalid: got %0d want %0d", n_valid - bv, 1);
    end
    run_period();
    tests++;
    if (n_valid != bv + 2 || v_period !== 16'd400 || v_locked !== 1'b0) begin
      fails++;
      $display("FAIL midreset_first: got valid=%0d period=%0d locked=%b want 2 400 0", n_valid - bv, v_period, v_locked);
    end
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_swapped();
    test_missing_channel();
    test_timeout();
    test_back_to_back_edges();
    test_reset_mid_period();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
